// File: rtl/connect4_game_if.sv
// Move request / result bundle between the input front-end and the Connect-4 sequencer.
// The board array is carried here as well because the VGA board renderer reads it.
interface connect4_game_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
);
    logic                             move_valid;
    logic [2:0]                       move_col;
    logic                             ready;
    logic                             move_ack;
    logic                             move_err;
    logic                             cur_player;
    logic [ROWS-1:0][COLS-1:0][1:0]   board;
    logic                             player1_win;
    logic                             player2_win;
    logic                             draw;

    modport master (
        output move_valid, move_col,
        input  ready, move_ack, move_err, cur_player, board,
               player1_win, player2_win, draw
    );

    modport slave (
        input  move_valid, move_col,
        output ready, move_ack, move_err, cur_player, board,
               player1_win, player2_win, draw
    );
endinterface

// File: rtl/connect4_game_ctrl.sv
// Connect-4 sequencer: drops pieces with gravity, then walks out from the placed cell
// in four directions and both senses to detect a win. It also tracks turns and the draw.
module connect4_game_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            new_game,
    connect4_game_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SCAN, PLACE, WALK, OVER} state_t;
    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    localparam logic [2:0]        LAST_ROW = 3'(ROWS - 1);
    localparam logic [3:0]        COLS_W   = 4'(COLS);
    localparam logic [3:0]        WIN_W    = 4'(WIN_LEN);
    localparam logic [5:0]        CELLS    = 6'(ROWS * COLS);
    localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
    localparam logic signed [4:0] COLS_S   = 5'(COLS);

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic       cur_player_q, cur_player_d;
    logic       p1_win_q, p1_win_d;
    logic       p2_win_q, p2_win_d;
    logic       draw_q, draw_d;
    logic [5:0] move_cnt_q, move_cnt_d;
    logic [2:0] r_q, r_d;
    logic [2:0] c_q, c_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] k_q, k_d;
    logic [1:0] dir_q, dir_d;
    logic       sense_q, sense_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    logic [1:0]        code;
    logic signed [4:0] ks, dr, dc, pr, pc;
    logic [2:0]        pr_idx, pc_idx;
    logic              in_bounds, probe_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            board_q      <= '0;
            cur_player_q <= 1'b0;
            p1_win_q     <= 1'b0;
            p2_win_q     <= 1'b0;
            draw_q       <= 1'b0;
            move_cnt_q   <= '0;
            r_q          <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            dir_q        <= '0;
            sense_q      <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            cur_player_q <= cur_player_d;
            p1_win_q     <= p1_win_d;
            p2_win_q     <= p2_win_d;
            draw_q       <= draw_d;
            move_cnt_q   <= move_cnt_d;
            r_q          <= r_d;
            c_q          <= c_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            dir_q        <= dir_d;
            sense_q      <= sense_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // Probe cell at distance k from the placed piece; sense '-' mirrors the direction.
    always_comb begin
        code = cur_player_q ? 2'b01 : 2'b10;
        ks   = $signed({1'b0, k_q});
        dr   = '0;
        dc   = '0;
        case (dir_q)
            2'd0: begin dr = '0;  dc = ks;  end
            2'd1: begin dr = ks;  dc = '0;  end
            2'd2: begin dr = ks;  dc = ks;  end
            default: begin dr = ks; dc = -ks; end
        endcase
        if (sense_q) begin
            dr = -dr;
            dc = -dc;
        end
        pr        = $signed({2'b00, r_q}) + dr;
        pc        = $signed({2'b00, c_q}) + dc;
        pr_idx    = pr[2:0];
        pc_idx    = pc[2:0];
        in_bounds = (pr >= 0) && (pr < ROWS_S) && (pc >= 0) && (pc < COLS_S);
        probe_hit = in_bounds && (board_q[pr_idx][pc_idx] == code);
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        cur_player_d = cur_player_q;
        p1_win_d     = p1_win_q;
        p2_win_d     = p2_win_q;
        draw_d       = draw_q;
        move_cnt_d   = move_cnt_q;
        r_d          = r_q;
        c_d          = c_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        dir_d        = dir_q;
        sense_d      = sense_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.move_valid) begin
                    if ({1'b0, bus.move_col} >= COLS_W) begin
                        err_d = 1'b1;
                    end else begin
                        c_d     = bus.move_col;
                        r_d     = LAST_ROW;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (board_q[r_q][c_q] == 2'b00) begin
                    state_d = PLACE;
                end else if (r_q == 3'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    r_d = r_q - 3'd1;
                end
            end
            PLACE: begin
                board_d[r_q][c_q] = code;
                cnt_d   = 4'd1;
                dir_d   = 2'd0;
                sense_d = 1'b0;
                k_d     = 4'd1;
                state_d = WALK;
            end
            WALK: begin
                if (probe_hit) begin
                    cnt_d = cnt_q + 4'd1;
                    k_d   = k_q + 4'd1;
                    if (cnt_q + 4'd1 >= WIN_W) begin
                        ack_d   = 1'b1;
                        state_d = OVER;
                        if (cur_player_q) p2_win_d = 1'b1;
                        else              p1_win_d = 1'b1;
                    end
                end else if (!sense_q) begin
                    sense_d = 1'b1;
                    k_d     = 4'd1;
                end else if (dir_q != 2'd3) begin
                    dir_d   = dir_q + 2'd1;
                    cnt_d   = 4'd1;
                    sense_d = 1'b0;
                    k_d     = 4'd1;
                end else begin
                    ack_d      = 1'b1;
                    move_cnt_d = move_cnt_q + 6'd1;
                    if (move_cnt_q + 6'd1 == CELLS) begin
                        draw_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        cur_player_d = ~cur_player_q;
                        state_d      = IDLE;
                    end
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase

        // Synchronous clear overrides any move in flight, including one sampled this cycle.
        if (new_game) begin
            state_d      = IDLE;
            board_d      = '0;
            cur_player_d = 1'b0;
            p1_win_d     = 1'b0;
            p2_win_d     = 1'b0;
            draw_d       = 1'b0;
            move_cnt_d   = '0;
            r_d          = '0;
            c_d          = '0;
            cnt_d        = '0;
            k_d          = '0;
            dir_d        = '0;
            sense_d      = 1'b0;
            ack_d        = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_comb begin
        bus.ready       = (state_q == IDLE);
        bus.move_ack    = ack_q;
        bus.move_err    = err_q;
        bus.cur_player  = cur_player_q;
        bus.board       = board_q;
        bus.player1_win = p1_win_q;
        bus.player2_win = p2_win_q;
        bus.draw        = draw_q;
    end
endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Directed bench for connect4_game_ctrl: a vector table for stacking and error cases,
// plus hand-written sequences for the wins, the ignored move, new_game and mid-walk reset.
module tb_connect4_game_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic new_game;

    connect4_game_if #(.ROWS(6), .COLS(7)) bus ();

    connect4_game_ctrl #(.ROWS(6), .COLS(7), .WIN_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_game (new_game),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         col;
        bit         exp_err;
        int         row;
        logic [1:0] code;
        logic       exp_cur;
    } vec_t;

    vec_t vecs[10];

    // One-cycle move request, then count ack/err pulses over a window longer than the worst case.
    task automatic raw_move(input logic [2:0] col, output int acks, output int errs,
                            output logic err_first);
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_col   = col;
        @(negedge clk);
        bus.move_valid = 1'b0;
        err_first = bus.move_err;
        acks = 0;
        errs = 0;
        for (int i = 0; i < 45; i++) begin
            if (bus.move_ack) acks++;
            if (bus.move_err) errs++;
            @(negedge clk);
        end
    endtask

    task automatic play(input logic [2:0] col, output int acks, output int errs,
                        output logic err_first);
        for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
        chk("ready_before_move", bus.ready, 1'b1);
        raw_move(col, acks, errs, err_first);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_board"}, bus.board, '0);
        chk({tag, "_cur_player"}, bus.cur_player, 1'b0);
        chk({tag, "_ready"}, bus.ready, 1'b1);
        chk({tag, "_flags"}, {bus.player1_win, bus.player2_win, bus.draw}, 3'b000);
        chk({tag, "_pulses"}, {bus.move_ack, bus.move_err}, 2'b00);
    endtask

    int         acks, errs;
    logic       err_first;
    logic [83:0] snap;
    int         hw_cols[7] = '{0, 0, 1, 1, 2, 2, 3};
    int         ad_cols[10] = '{1, 0, 2, 1, 2, 2, 3, 3, 3, 3};

    initial begin
        vecs[0] = '{3, 1'b0, 5, 2'b10, 1'b1};
        vecs[1] = '{3, 1'b0, 4, 2'b01, 1'b0};
        vecs[2] = '{0, 1'b0, 5, 2'b10, 1'b1};
        vecs[3] = '{0, 1'b0, 4, 2'b01, 1'b0};
        vecs[4] = '{0, 1'b0, 3, 2'b10, 1'b1};
        vecs[5] = '{0, 1'b0, 2, 2'b01, 1'b0};
        vecs[6] = '{0, 1'b0, 1, 2'b10, 1'b1};
        vecs[7] = '{0, 1'b0, 0, 2'b01, 1'b0};
        vecs[8] = '{0, 1'b1, 0, 2'b00, 1'b0};
        vecs[9] = '{7, 1'b1, 0, 2'b00, 1'b0};

        rst            = 1'b1;
        new_game       = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_col   = 3'd0;
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            snap = bus.board;
            play(3'(vecs[v].col), acks, errs, err_first);
            if (vecs[v].exp_err) begin
                chk($sformatf("v%0d_err_cnt", v), errs, 1);
                chk($sformatf("v%0d_ack_cnt", v), acks, 0);
                chk($sformatf("v%0d_board_same", v), bus.board, snap);
                chk($sformatf("v%0d_ready", v), bus.ready, 1'b1);
                if (vecs[v].col >= 7) chk($sformatf("v%0d_err_next_cycle", v), err_first, 1'b1);
            end else begin
                chk($sformatf("v%0d_ack_cnt", v), acks, 1);
                chk($sformatf("v%0d_err_cnt", v), errs, 0);
                chk($sformatf("v%0d_cell", v), bus.board[vecs[v].row][vecs[v].col], vecs[v].code);
            end
            chk($sformatf("v%0d_cur_player", v), bus.cur_player, vecs[v].exp_cur);
        end

        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_cleared("new_game1");

        // Player 1 completes the bottom row with cols 0..3.
        for (int i = 0; i < 7; i++) begin
            play(3'(hw_cols[i]), acks, errs, err_first);
            chk($sformatf("hw%0d_ack_cnt", i), acks, 1);
        end
        chk("hw_p1_win", bus.player1_win, 1'b1);
        chk("hw_p2_win", bus.player2_win, 1'b0);
        chk("hw_ready", bus.ready, 1'b0);
        chk("hw_cur_player", bus.cur_player, 1'b0);
        chk("hw_cell", bus.board[5][3], 2'b10);

        snap = bus.board;
        raw_move(3'd4, acks, errs, err_first);
        chk("over_ack_cnt", acks, 0);
        chk("over_err_cnt", errs, 0);
        chk("over_board_same", bus.board, snap);
        chk("over_p1_win", bus.player1_win, 1'b1);

        @(negedge clk);
        new_game = 1'b1;
        bus.move_valid = 1'b1;
        bus.move_col   = 3'd2;
        @(negedge clk);
        new_game = 1'b0;
        bus.move_valid = 1'b0;
        check_cleared("new_game2");
        repeat (3) @(negedge clk);
        chk("ng_move_discarded", bus.board, '0);

        // Reset while the walk for a fresh piece is running.
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_col   = 3'd5;
        @(negedge clk);
        bus.move_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midwalk_busy", bus.ready, 1'b0);
        chk("midwalk_cell", bus.board[5][5], 2'b10);
        #2 rst = 1'b1;
        #1 check_cleared("midwalk_rst");
        @(negedge clk);
        rst = 1'b0;

        // Player 2 builds (5,0),(4,1),(3,2),(2,3).
        for (int i = 0; i < 10; i++) begin
            play(3'(ad_cols[i]), acks, errs, err_first);
            chk($sformatf("ad%0d_ack_cnt", i), acks, 1);
        end
        chk("ad_p2_win", bus.player2_win, 1'b1);
        chk("ad_p1_win", bus.player1_win, 1'b0);
        chk("ad_cur_player", bus.cur_player, 1'b1);
        chk("ad_ready", bus.ready, 1'b0);
        chk("ad_cell", bus.board[2][3], 2'b01);
        chk("ad_draw", bus.draw, 1'b0);

        #2 rst = 1'b1;
        #1 check_cleared("final_rst");
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
